// File: rtl/rs232_pkg.sv
// Shared definitions for the rs-232 word transmitter/receiver pair:
// receiver state encoding and the default link parameters.
package rs232_pkg;

  localparam int CLKS_PER_BIT_DEF   = 42;
  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int GAP_BITS_DEF       = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the serial receiver. Counts clk cycles from the last
// restart or wrap and flags the half-bit and full-bit points.
module rx_bit_timer
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);

  // Free-running bit counter; restart holds it at zero, a full bit wraps it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_word_receiver.sv
// 8N1 serial receiver that assembles BYTES_PER_WORD bytes (byte 0 first,
// LSB bit first) into one word and presents it with a single-cycle strobe.
module rx_word_receiver
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int GAP_BITS       = GAP_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_in,
  output logic [8*BYTES_PER_WORD-1:0] data_out,
  output logic                        data_valid,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int WORD_W    = 8 * BYTES_PER_WORD;
  localparam int IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT);

  rx_state_t         state;
  logic              sync_p0;
  logic              sync_p1;
  logic              line_prev;
  logic              line;
  logic              fall;
  logic [2:0]        bit_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        shreg;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] word_next;
  logic              restart;
  logic              half_tick;
  logic              full_tick;

  assign line = sync_p1;
  // line_prev must have been high for a clk, so a start is only seen after idle-high.
  assign fall = line_prev & ~line;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_p0   <= data_in;
      sync_p1   <= sync_p0;
      line_prev <= sync_p1;
    end
  end

  // Timer is held at zero while waiting for a start edge and re-phased at mid start bit.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE, GAP: restart = 1'b1;
      START:     restart = half_tick;
      default:   restart = 1'b0;
    endcase
  end

  // Current partial word with the just-received byte dropped into its slot.
  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = shreg;
  end

  // Byte shift register and word assembly; every slot is rewritten before a word is shown.
  always_ff @(posedge clk) begin
    if (state == DATA && full_tick) begin
      shreg <= {line, shreg[7:1]};
    end
    if (state == STOP && full_tick && line) begin
      word <= word_next;
    end
  end

  // Receive FSM with registered status outputs and the output word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (half_tick) begin
            if (!line) begin
              state <= DATA;
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        DATA: begin
          if (full_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (full_tick) begin
            if (line) begin
              if (byte_idx == LAST_IDX) begin
                data_out   <= word_next;
                data_valid <= 1'b1;
                byte_idx   <= '0;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                byte_idx <= byte_idx + IDX_W'(1);
                gap_cnt  <= '0;
                state    <= GAP;
              end
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        GAP: begin
          if (fall) begin
            state   <= START;
            bit_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            byte_idx <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_word_receiver.sv
// Self-checking bench for rx_word_receiver: directed link scenarios plus
// random words, compared against a byte-list model of the transmitted words.
module tb_rx_word_receiver;

  localparam int CPB = 42;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_in = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  rx_word_receiver #(
    .CLKS_PER_BIT  (CPB),
    .BYTES_PER_WORD(4),
    .GAP_BITS      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  int stray_cnt = 0;
  logic [31:0] prev_out = '0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  wb[4];

  // Record output events away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_out = data_out;
    end else begin
      if (data_valid) begin
        valid_cnt++;
        got_q.push_back(data_out);
      end
      if (frame_err) ferr_cnt++;
      if (data_valid && frame_err) overlap_cnt++;
      if (!data_valid && data_out !== prev_out) stray_cnt++;
      prev_out = data_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    valid_cnt = 0;
    ferr_cnt  = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle_bits(input int n);
    data_in = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    data_in = stop_bit;
    repeat (CPB) @(negedge clk);
    data_in = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] b[4], input int gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(b[k], 1'b1);
      if (k < 3 && gap > 0) idle_bits(gap);
    end
  endtask

  // Word value as the byte list weighted by powers of 256.
  function automatic logic [31:0] model_word(input logic [7:0] b[4]);
    longint unsigned w = 0;
    longint unsigned weight = 1;
    for (int k = 0; k < 4; k++) begin
      w = w + longint'(b[k]) * weight;
      weight = weight * 256;
    end
    return 32'(w);
  endfunction

  task automatic check_words(input string tag);
    int n = 0;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk($sformatf("%s_word%0d", tag, n), got_q.pop_front(), exp_q.pop_front());
      n++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_valid", {31'b0, data_valid}, 32'h0);
    chk("reset_ferr", {31'b0, frame_err}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    idle_bits(2);

    // Single word
    clear_events();
    wb = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    send_word(wb, 0);
    exp_q.push_back(32'hF00F3CA5);
    idle_bits(2);
    check_words("w1");
    chk("w1_ferr", 32'(ferr_cnt), 32'd0);
    chk("w1_busy", {31'b0, busy}, 32'h0);

    // Two consecutive words
    clear_events();
    wb = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_word(wb, 0);
    wb = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_word(wb, 0);
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    idle_bits(2);
    check_words("w2");

    // Bad stop bit on byte 2, then a clean word
    clear_events();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    idle_bits(3);
    chk("stop_ferr", 32'(ferr_cnt), 32'd1);
    chk("stop_valid", 32'(valid_cnt), 32'd0);
    chk("stop_busy", {31'b0, busy}, 32'h0);
    clear_events();
    wb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_word(wb, 0);
    exp_q.push_back(32'hEFBEADDE);
    idle_bits(2);
    check_words("after_stop");
    chk("after_stop_ferr", 32'(ferr_cnt), 32'd0);

    // Short low glitch on the idle line
    clear_events();
    data_in = 1'b0;
    repeat (10) @(negedge clk);
    idle_bits(2);
    chk("glitch_ferr", 32'(ferr_cnt), 32'd1);
    chk("glitch_busy", {31'b0, busy}, 32'h0);
    chk("glitch_valid", 32'(valid_cnt), 32'd0);

    // Three bytes, overlong gap, then a full word
    clear_events();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    idle_bits(40);
    chk("gap_busy", {31'b0, busy}, 32'h0);
    wb = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_word(wb, 0);
    exp_q.push_back(32'h04030201);
    idle_bits(2);
    check_words("gap");
    chk("gap_ferr", 32'(ferr_cnt), 32'd0);

    // Asynchronous reset in the middle of byte 1
    clear_events();
    send_byte(8'h5A, 1'b1);
    data_in = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("midrst_busy_before", {31'b0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_valid", {31'b0, data_valid}, 32'h0);
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_bits(2);
    chk("release_valid", 32'(valid_cnt), 32'd0);
    chk("release_ferr", 32'(ferr_cnt), 32'd0);
    wb = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
    send_word(wb, 0);
    exp_q.push_back(32'hF00F3CA5);
    idle_bits(2);
    check_words("postrst");

    // Random words with random short inter-byte gaps
    clear_events();
    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < 4; k++) wb[k] = 8'($urandom_range(0, 255));
      send_word(wb, int'($urandom_range(0, 4)));
      exp_q.push_back(model_word(wb));
      idle_bits(int'($urandom_range(1, 3)));
    end
    idle_bits(2);
    check_words("rand");
    chk("rand_ferr", 32'(ferr_cnt), 32'd0);

    // Whole-run properties
    chk("valid_ferr_overlap", 32'(overlap_cnt), 32'd0);
    chk("data_out_without_valid", 32'(stray_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
